// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle base ops, iterative unsigned multiply/divide,
// valid/ready handshakes on request and result sides.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] C_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div0,
   output logic             illegal
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [OP_W-1:0] op_add  = OP_W'(0);
   localparam logic [OP_W-1:0] op_sub  = OP_W'(1);
   localparam logic [OP_W-1:0] op_and  = OP_W'(2);
   localparam logic [OP_W-1:0] op_or   = OP_W'(3);
   localparam logic [OP_W-1:0] op_srl  = OP_W'(4);
   localparam logic [OP_W-1:0] op_sra  = OP_W'(5);
   localparam logic [OP_W-1:0] op_sll  = OP_W'(6);
   localparam logic [OP_W-1:0] op_xor  = OP_W'(7);
   localparam logic [OP_W-1:0] op_slt  = OP_W'(8);
   localparam logic [OP_W-1:0] op_sltu = OP_W'(9);
   localparam logic [OP_W-1:0] op_mulu = OP_W'(10);
   localparam logic [OP_W-1:0] op_divu = OP_W'(11);

   typedef enum logic [1:0] {s_idle, s_calc, s_done} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  b_q, hi_q, lo_q;
   logic [OP_W-1:0]   op_q;
   logic [SH_W-1:0]   cnt_q;

   logic [SH_W-1:0]   sh;
   logic [WIDTH-1:0]  sum, diff, b_neg, res, res_hi;
   logic              ovf, dz, ill, multi;
   logic [WIDTH:0]    mul_sum, div_sh;
   logic [WIDTH-1:0]  div_sub, hi_n, lo_n;
   logic              last;

   // Single-cycle result path, evaluated directly on the request inputs
   always_comb begin
      sh     = B[SH_W-1:0];
      sum    = A + B;
      diff   = A - B;
      b_neg  = ~B + 1'b1;
      res    = '0;
      res_hi = '0;
      ovf    = 1'b0;
      dz     = 1'b0;
      ill    = 1'b0;
      multi  = 1'b0;
      case (ALUOp)
         op_add: begin
            res = sum;
            ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         op_sub: begin
            res = diff;
            ovf = (A[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         op_and:  res = A & B;
         op_or:   res = A | B;
         op_srl:  res = A >> sh;
         op_sra:  res = $signed(A) >>> sh;
         op_sll:  res = A << sh;
         op_xor:  res = A ^ B;
         op_slt:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         op_sltu: res = {{(WIDTH-1){1'b0}}, A < B};
         op_mulu: multi = 1'b1;
         op_divu: begin
            if (B == '0) begin
               res    = '1;
               res_hi = A;
               dz     = 1'b1;
            end else begin
               multi = 1'b1;
            end
         end
         default: ill = 1'b1;
      endcase
   end

   // One iteration: hi/lo hold the product, or remainder/quotient for divide
   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
      div_sh  = {hi_q, lo_q[WIDTH-1]};
      div_sub = div_sh[WIDTH-1:0] - b_q;
      last    = (cnt_q == SH_W'(WIDTH - 1));
      if (op_q == op_divu) begin
         if (div_sh >= {1'b0, b_q}) begin
            hi_n = div_sub;
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = div_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == s_idle);
      out_valid = (state_q == s_done);
      case (state_q)
         s_idle:  if (in_valid) state_d = multi ? s_calc : s_done;
         s_calc:  if (last) state_d = s_done;
         s_done:  if (out_ready) state_d = s_idle;
         default: state_d = s_idle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= s_idle;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         b_q      <= '0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         C        <= '0;
         C_hi     <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         div0     <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         case (state_q)
            s_idle: begin
               if (in_valid) begin
                  b_q   <= B;
                  op_q  <= ALUOp;
                  lo_q  <= A;
                  hi_q  <= '0;
                  cnt_q <= '0;
                  if (!multi) begin
                     C        <= res;
                     C_hi     <= res_hi;
                     zero     <= (res == '0);
                     overflow <= ovf;
                     div0     <= dz;
                     illegal  <= ill;
                  end
               end
            end
            s_calc: begin
               hi_q  <= hi_n;
               lo_q  <= lo_n;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  C        <= lo_n;
                  C_hi     <= hi_n;
                  zero     <= (lo_n == '0);
                  overflow <= 1'b0;
                  div0     <= 1'b0;
                  illegal  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, latency, stall, and reset checks.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  op = '0;
   logic        in_ready, out_valid, zero, overflow, div0, illegal;
   logic [31:0] c, c_hi;

   int errors = 0;
   int checks = 0;

   alu_mc #(.WIDTH(32), .OP_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .ALUOp     (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (c),
      .C_hi      (c_hi),
      .zero      (zero),
      .overflow  (overflow),
      .div0      (div0),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request and return #1 after its accept edge with inputs scrambled
   task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop);
      int n;
      @(negedge clk);
      a = va; b = vb; op = vop; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 64'(n < 100), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~va; b = ~vb;
   endtask

   // Cycles counted from the accept edge; 1 = valid in the cycle right after accept
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // flags = {zero, overflow, div0, illegal}
   task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic [3:0] vop, input logic [31:0] ec, input logic [31:0] ehi,
                      input logic [3:0] eflags, input int elat);
      int lat;
      send(va, vb, vop);
      wait_valid(lat);
      check({tag, "_lat"}, 64'(lat), 64'(elat));
      check({tag, "_c"}, 64'(c), 64'(ec));
      check({tag, "_chi"}, 64'(c_hi), 64'(ehi));
      check({tag, "_flags"}, 64'({zero, overflow, div0, illegal}), 64'(eflags));
      take();
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_c", 64'({c_hi, c}), 64'd0);
      check("rst_flags", 64'({zero, overflow, div0, illegal}), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000, 32'h0, 4'b0100, 1);
      run("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  32'h0000_0000, 32'h0, 4'b1000, 1);
      run("sub_ovf",  32'h8000_0000, 32'h0000_0001, 4'd1,  32'h7FFF_FFFF, 32'h0, 4'b0100, 1);
      run("sub_zero", 32'h0000_0005, 32'h0000_0005, 4'd1,  32'h0000_0000, 32'h0, 4'b1000, 1);
      run("and",      32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  32'hF000_F000, 32'h0, 4'b0000, 1);
      run("or",       32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3,  32'hFFF0_FFF0, 32'h0, 4'b0000, 1);
      run("srl",      32'h8000_0000, 32'h0000_0024, 4'd4,  32'h0800_0000, 32'h0, 4'b0000, 1);
      run("sra",      32'h8000_0000, 32'h0000_0024, 4'd5,  32'hF800_0000, 32'h0, 4'b0000, 1);
      run("sll",      32'h0000_0001, 32'hFFFF_FFFF, 4'd6,  32'h8000_0000, 32'h0, 4'b0000, 1);
      run("xor",      32'hA5A5_A5A5, 32'hFFFF_0000, 4'd7,  32'h5A5A_A5A5, 32'h0, 4'b0000, 1);
      run("slt",      32'hFFFF_FFFF, 32'h0000_0001, 4'd8,  32'h0000_0001, 32'h0, 4'b0000, 1);
      run("sltu",     32'hFFFF_FFFF, 32'h0000_0001, 4'd9,  32'h0000_0000, 32'h0, 4'b1000, 1);
      run("mul_a",    32'hFFFF_FFFF, 32'h0000_0002, 4'd10, 32'hFFFF_FFFE, 32'h1, 4'b0000, 33);
      run("mul_zlo",  32'h0001_0000, 32'h0001_0000, 4'd10, 32'h0000_0000, 32'h1, 4'b1000, 33);
      run("mul_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h0000_0001, 32'hFFFF_FFFE,
          4'b0000, 33);
      run("div_a",    32'd100,       32'd7,         4'd11, 32'd14,        32'd2, 4'b0000, 33);
      run("div_b",    32'hFFFF_FFFF, 32'd10,        4'd11, 32'h1999_9999, 32'd5, 4'b0000, 33);
      run("div0",     32'd7,         32'd0,         4'd11, 32'hFFFF_FFFF, 32'd7, 4'b0010, 1);
      run("illegal",  32'd5,         32'd6,         4'd13, 32'h0,         32'h0, 4'b1001, 1);

      // Result held under back-pressure; a held request waits for IDLE
      send(32'd3, 32'd4, 4'd0);
      wait_valid(lat);
      check("stall_lat", 64'(lat), 64'd1);
      @(negedge clk);
      a = 32'd10; b = 32'd2; op = 4'd1; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_c", 64'(c), 64'd7);
         check("stall_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("handoff_valid", 64'(out_valid), 64'd0);
      check("handoff_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("held_valid", 64'(out_valid), 64'd1);
      check("held_c", 64'(c), 64'd8);
      take();

      // Reset in the middle of a multiply
      send(32'hFFFF_FFFF, 32'd3, 4'd10);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      check("midrst_c", 64'({c_hi, c}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run("post_rst", 32'd2, 32'd3, 4'd0, 32'd5, 32'h0, 4'b0000, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
